// File: rtl/srcnn_mac_pkg.sv
// Shared defaults, legal ranges and the output round/saturate helper for the
// SRCNN multiply-accumulate pipeline.
package srcnn_mac_pkg;

  localparam int DIN0_W_DEF     = 16;
  localparam int DIN1_W_DEF     = 16;
  localparam int ACC_W_DEF      = 40;
  localparam int FRAC_SHIFT_DEF = 12;
  localparam int DOUT_W_DEF     = 16;

  localparam int NUM_STAGE_MIN  = 1;
  localparam int NUM_STAGE_MAX  = 4;

  // The helper works in a fixed 64-bit signed domain; keeping the accumulator
  // two bits narrower leaves headroom for the rounding constant.
  localparam int RS_W           = 64;
  localparam int ACC_W_MAX      = RS_W - 2;

  typedef struct packed {
    logic                   sat;
    logic signed [RS_W-1:0] val;
  } rs_t;

  // Round half up by FRAC_SHIFT, arithmetic shift right, then clip to a
  // signed dout_w-bit range and flag whether clipping happened.
  function automatic rs_t round_sat(input logic signed [RS_W-1:0] sum,
                                    input int                     frac,
                                    input int                     dout_w);
    rs_t                    res;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    r = sum;
    if (frac > 0) begin
      r = r + (64'sd1 <<< (frac - 1));
    end
    r  = r >>> frac;
    hi = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dout_w - 1));
    res.sat = 1'b0;
    res.val = r;
    if (r > hi) begin
      res.sat = 1'b1;
      res.val = hi;
    end else if (r < lo) begin
      res.sat = 1'b1;
      res.val = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/srcnn_mac_mul_pipe.sv
// Full-precision signed multiplier followed by NUM_STAGE enable-gated
// registers; valid and last sidebands travel alongside every stage.
module srcnn_mac_mul_pipe
  import srcnn_mac_pkg::*;
#(
  parameter int A_W       = DIN0_W_DEF,
  parameter int B_W       = DIN1_W_DEF,
  parameter int A_SIGNED  = 0,
  parameter int NUM_STAGE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [A_W-1:0]           a,
  input  logic signed [B_W-1:0]    b,
  input  logic                     in_vld,
  input  logic                     in_last,
  output logic signed [A_W+B_W:0]  prod,
  output logic                     out_vld,
  output logic                     out_last
);

  localparam int P_W = A_W + B_W + 1;

  logic [A_W:0]           a_ext;
  logic signed [P_W-1:0]  a_x;
  logic signed [P_W-1:0]  b_x;
  logic signed [P_W-1:0]  prod_p0;

  logic signed [P_W-1:0]  prod_q [NUM_STAGE];
  logic signed [P_W-1:0]  prod_d [NUM_STAGE];
  logic [NUM_STAGE-1:0]   vld_q;
  logic [NUM_STAGE-1:0]   vld_d;
  logic [NUM_STAGE-1:0]   last_q;
  logic [NUM_STAGE-1:0]   last_d;

  // Extend both operands to the product width so the multiply is exact.
  always_comb begin
    a_ext   = (A_SIGNED != 0) ? {a[A_W-1], a} : {1'b0, a};
    a_x     = {{B_W{a_ext[A_W]}}, a_ext};
    b_x     = {{(A_W+1){b[B_W-1]}}, b};
    prod_p0 = a_x * b_x;
  end

  // Shift every stage forward when enabled, otherwise hold.
  always_comb begin
    prod_d = prod_q;
    vld_d  = vld_q;
    last_d = last_q;
    if (en) begin
      prod_d[0] = prod_p0;
      vld_d[0]  = in_vld;
      last_d[0] = in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_d[i] = prod_q[i-1];
        vld_d[i]  = vld_q[i-1];
        last_d[i] = last_q[i-1];
      end
    end
  end

  // Sideband control bits are cleared by reset so in-flight beats vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  // Product data needs no reset; it is qualified by the valid bits.
  always_ff @(posedge clk) begin
    prod_q <= prod_d;
  end

  assign prod     = prod_q[NUM_STAGE-1];
  assign out_vld  = vld_q[NUM_STAGE-1];
  assign out_last = last_q[NUM_STAGE-1];

endmodule

// File: rtl/srcnn_mac_pipe.sv
// Windowed multiply-accumulate: pipelined products are summed until a beat
// marked last, then the sum is rounded, saturated and held for downstream.
module srcnn_mac_pipe
  import srcnn_mac_pkg::*;
#(
  parameter int din0_WIDTH  = DIN0_W_DEF,
  parameter int din1_WIDTH  = DIN1_W_DEF,
  parameter int NUM_STAGE   = 2,
  parameter int DIN0_SIGNED = 0,
  parameter int ACC_WIDTH   = ACC_W_DEF,
  parameter int FRAC_SHIFT  = FRAC_SHIFT_DEF,
  parameter int dout_WIDTH  = DOUT_W_DEF
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [din0_WIDTH-1:0]        din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  input  logic                         in_last,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         dout_sat,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int P_W = din0_WIDTH + din1_WIDTH + 1;

  if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_num_stage
    $error("srcnn_mac_pipe: NUM_STAGE must be in 1..4");
  end
  if (ACC_WIDTH < P_W || ACC_WIDTH > ACC_W_MAX) begin : g_bad_acc_width
    $error("srcnn_mac_pipe: ACC_WIDTH must cover the full product plus sign and fit 62 bits");
  end
  if (FRAC_SHIFT < 0 || FRAC_SHIFT > ACC_WIDTH - 2) begin : g_bad_frac_shift
    $error("srcnn_mac_pipe: FRAC_SHIFT must be in 0..ACC_WIDTH-2");
  end
  if (dout_WIDTH < 2 || dout_WIDTH > ACC_WIDTH) begin : g_bad_dout_width
    $error("srcnn_mac_pipe: dout_WIDTH must be in 2..ACC_WIDTH");
  end

  logic                        stall;
  logic signed [P_W-1:0]       mul_prod;
  logic                        mul_vld;
  logic                        mul_last;

  logic signed [ACC_WIDTH-1:0] acc_sum;
  rs_t                         rs;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [dout_WIDTH-1:0] dout_q, dout_d;
  logic                        dout_sat_q, dout_sat_d;
  logic                        out_valid_q, out_valid_d;

  // A held result that downstream refuses freezes the whole datapath.
  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  srcnn_mac_mul_pipe #(
    .A_W       (din0_WIDTH),
    .B_W       (din1_WIDTH),
    .A_SIGNED  (DIN0_SIGNED),
    .NUM_STAGE (NUM_STAGE)
  ) u_mul (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .en       (~stall),
    .a        (din0),
    .b        (din1),
    .in_vld   (in_valid & in_ready),
    .in_last  (in_last),
    .prod     (mul_prod),
    .out_vld  (mul_vld),
    .out_last (mul_last)
  );

  // Accumulate products; on the last beat emit the rounded sum and restart.
  always_comb begin
    acc_sum     = acc_q + ACC_WIDTH'(mul_prod);
    rs          = round_sat(RS_W'(acc_sum), FRAC_SHIFT, dout_WIDTH);
    acc_d       = acc_q;
    dout_d      = dout_q;
    dout_sat_d  = dout_sat_q;
    out_valid_d = out_valid_q;
    if (!stall) begin
      // Not stalled means any held result was taken this cycle.
      out_valid_d = 1'b0;
      if (mul_vld) begin
        if (mul_last) begin
          acc_d       = '0;
          dout_d      = rs.val[dout_WIDTH-1:0];
          dout_sat_d  = rs.sat;
          out_valid_d = 1'b1;
        end else begin
          acc_d = acc_sum;
        end
      end
    end
  end

  // Accumulator and output registers, cleared by the asynchronous reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q       <= '0;
      dout_q      <= '0;
      dout_sat_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      dout_q      <= dout_d;
      dout_sat_q  <= dout_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dout      = dout_q;
  assign dout_sat  = dout_sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_srcnn_mac_pipe.sv
// Directed bench for srcnn_mac_pipe: default instance plus a signed-din0
// instance, hand-computed expected values.
module tb_srcnn_mac_pipe;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n;
  logic [15:0]        din0;
  logic signed [15:0] din1;
  logic               in_last, in_valid, in_ready;
  logic signed [15:0] dout;
  logic               dout_sat, out_valid, out_ready;

  logic [15:0]        s_din0;
  logic signed [15:0] s_din1;
  logic               s_in_last, s_in_valid, s_in_ready;
  logic signed [15:0] s_dout;
  logic               s_dout_sat, s_out_valid;

  int n_vec = 0;
  int n_bad = 0;

  always #5 ap_clk = ~ap_clk;

  srcnn_mac_pipe u_dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .din0      (din0),
    .din1      (din1),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .dout_sat  (dout_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  srcnn_mac_pipe #(.DIN0_SIGNED(1)) u_dut_s (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .din0      (s_din0),
    .din1      (s_din1),
    .in_last   (s_in_last),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .dout      (s_dout),
    .dout_sat  (s_dout_sat),
    .out_valid (s_out_valid),
    .out_ready (1'b1)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present one beat at a falling edge and return at the next falling edge.
  task automatic send(input logic [15:0] a, input logic signed [15:0] b, input logic last);
    din0     = a;
    din1     = b;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  // Wait (bounded) for a result and compare it.
  task automatic wait_out(input string tag, input longint exp_dout, input longint exp_sat);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge ap_clk);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_dout"}, dout, exp_dout);
    chk({tag, "_sat"}, dout_sat, exp_sat);
  endtask

  initial begin
    din0 = '0; din1 = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    s_din0 = '0; s_din1 = '0; s_in_last = 1'b0; s_in_valid = 1'b0;
    ap_rst_n = 1'b0;

    repeat (2) @(negedge ap_clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_sat", dout_sat, 0);
    chk("rst_s_out_valid", s_out_valid, 0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Single-beat window: 4096*4096 = 2^24, >>12 -> 4096, valid on 3rd edge.
    send(16'd4096, 16'sd4096, 1'b1);
    in_valid = 1'b0;
    chk("lat_edge1", out_valid, 0);
    @(negedge ap_clk);
    chk("lat_edge2", out_valid, 0);
    @(negedge ap_clk);
    chk("lat_edge3", out_valid, 1);
    chk("one_dout", dout, 4096);
    chk("one_sat", dout_sat, 0);
    @(negedge ap_clk);
    chk("one_drop", out_valid, 0);

    // -2^24 + 2^24 + 2^24 = 2^24 -> 4096.
    send(16'd4096, -16'sd4096, 1'b0);
    send(16'd8192, 16'sd2048, 1'b0);
    send(16'd8192, 16'sd2048, 1'b1);
    in_valid = 1'b0;
    wait_out("sum3", 4096, 0);
    @(negedge ap_clk);

    // Rounding: 2048+2048=4096 -> 1; -6144+2048=-4096 -> -1; -2048+2048=0 -> 0.
    send(16'd1, 16'sd2048, 1'b1);
    in_valid = 1'b0;
    wait_out("rnd_half_pos", 1, 0);
    @(negedge ap_clk);
    send(16'd3, -16'sd2048, 1'b1);
    in_valid = 1'b0;
    wait_out("rnd_neg", -1, 0);
    @(negedge ap_clk);
    send(16'd1, -16'sd2048, 1'b1);
    in_valid = 1'b0;
    wait_out("rnd_half_neg", 0, 0);
    @(negedge ap_clk);

    // 4 * 65535*32767 >> 12 is far above 32767 -> clip high.
    repeat (3) send(16'd65535, 16'sd32767, 1'b0);
    send(16'd65535, 16'sd32767, 1'b1);
    in_valid = 1'b0;
    wait_out("sat_hi", 32767, 1);
    @(negedge ap_clk);

    // 4 * 65535*-32768 >> 12 is far below -32768 -> clip low.
    repeat (3) send(16'd65535, -16'sd32768, 1'b0);
    send(16'd65535, -16'sd32768, 1'b1);
    in_valid = 1'b0;
    wait_out("sat_lo", -32768, 1);
    @(negedge ap_clk);

    // Back-to-back single-beat windows: results on consecutive cycles.
    send(16'd4096, 16'sd4096, 1'b1);
    send(16'd8192, 16'sd4096, 1'b1);
    send(16'd4096, -16'sd4096, 1'b1);
    in_valid = 1'b0;
    chk("b2b0_vld", out_valid, 1);
    chk("b2b0_dout", dout, 4096);
    @(negedge ap_clk);
    chk("b2b1_vld", out_valid, 1);
    chk("b2b1_dout", dout, 8192);
    @(negedge ap_clk);
    chk("b2b2_vld", out_valid, 1);
    chk("b2b2_dout", dout, -4096);
    @(negedge ap_clk);
    chk("b2b_drop", out_valid, 0);

    // Backpressure: 2048*4096 = 2^23 -> 2048 held while out_ready=0.
    out_ready = 1'b0;
    send(16'd2048, 16'sd4096, 1'b1);
    in_valid = 1'b0;
    wait_out("stall_res", 2048, 0);
    din0 = 16'd4096; din1 = 16'sd4096; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_dout", dout, 2048);
      chk("stall_vld", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0;
    chk("stall_release_drop", out_valid, 0);
    wait_out("after_stall", 4096, 0);
    @(negedge ap_clk);

    // Reset in the middle of a window: partial sum and in-flight beats lost.
    send(16'd4096, 16'sd4096, 1'b0);
    send(16'd4096, 16'sd4096, 1'b0);
    in_valid = 1'b0;
    ap_rst_n = 1'b0;
    #1;
    chk("midrst_vld", out_valid, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("midrst_after_in_ready", in_ready, 1);
    // 2048*2048 = 2^22 -> 1024.
    send(16'd2048, 16'sd2048, 1'b1);
    in_valid = 1'b0;
    wait_out("after_rst", 1024, 0);
    @(negedge ap_clk);

    // Signed din0: 0xFFFF = -1, * 4096 = -4096, +2048 >>> 12 -> -1.
    s_din0 = 16'hFFFF; s_din1 = 16'sd4096; s_in_last = 1'b1; s_in_valid = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    s_in_valid = 1'b0;
    for (int i = 0; i < 20 && !s_out_valid; i++) @(negedge ap_clk);
    chk("signed_vld", s_out_valid, 1);
    chk("signed_dout", s_dout, -1);
    chk("signed_sat", s_dout_sat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
